cnt_bcd_display: RTL and testbench
==================================

Name: cnt_bcd_display

Overview:
- Downstream consumer of the 8-bit counter (tt_um_Compt_8bits).
- Takes the counter's binary value and converts it to three BCD digits with an iterative double-dabble engine.
- Drives a time-multiplexed 3-digit 7-segment display from the latest converted result.
- Sits between the counter's uo_out and the board display pins.

Parameters:
- REFRESH_DIV, 1024: clock cycles each digit stays selected; legal range 2..65535.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_out; dig_sel is always active-high.
- BLANK_LZ, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-low reset.
- bin_in  in  8  binary value from counter.
- bin_valid  in  1  request conversion of bin_in.
- busy  out  1  conversion in progress; requests ignored while high.
- bcd_valid  out  1  one-cycle pulse, new bcd_out available.
- bcd_out  out  12  {hundreds,tens,ones} BCD, held between conversions.
- seg_out  out  7  {g,f,e,d,c,b,a} for the selected digit.
- dig_sel  out  3  one-hot digit enable; bit0=ones, bit1=tens, bit2=hundreds.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-low, sampled on the rising clk edge only.
- Reset values:
  - bcd_out=0, bcd_valid=0, busy=0.
  - FSM state IDLE, shift count 0, refresh counter 0, digit index 0.
  - dig_sel=3'b001; seg_out shows "0" (7'b0111111, inverted if SEG_ACTIVE_LOW).
- FSM states IDLE, SHIFT, DONE:
  - IDLE: if bin_valid=1 at edge k, load a 20-bit work register {12'b0, bin_in}, clear the shift count, go to SHIFT. busy=1 from the cycle after edge k.
  - SHIFT: on each edge, add 3 to every BCD nibble >=5, then shift the whole register left 1 (both done in the same cycle). After the 8th shift, go to DONE.
  - DONE: on the next edge, copy the work register's BCD field to bcd_out, pulse bcd_valid for exactly one cycle, drop busy, return to IDLE.
- Latency: bcd_out/bcd_valid update at edge k+9; busy high for 9 cycles. Throughput: one conversion per 10 cycles minimum.
- bin_valid while busy=1, including the bcd_valid cycle: ignored, not queued.
- bcd_out changes only at DONE; the display always shows the last completed conversion.
- Display refresh:
  - Refresh counter counts 0..REFRESH_DIV-1, free-running and independent of the FSM.
  - On wrap, digit index advances 0->1->2->0.
  - dig_sel and seg_out are registered and update together, so there is no glitch between digits.
- Segment decode: digits 0-9 use standard common-cathode patterns. Nibble >9 (unreachable) decodes to blank (7'b0).
- Blanking with BLANK_LZ=1:
  - Hundreds blank when hundreds=0.
  - Tens blank when hundreds=0 and tens=0.
  - Ones never blanked.
  - Blank = all segments off, respecting polarity; dig_sel still rotates.
- Reset mid-conversion: conversion aborted; no bcd_valid pulse; bcd_out=0.
- Reset overrides bin_valid in the same cycle.

Decomposition:
- Package cnt_disp_pkg:
  - FSM state enum {IDLE, SHIFT, DONE}.
  - NUM_DIGITS=3, BIN_W=8, BCD_W=12.
  - 7-segment constant array SEG_LUT[0:9] and SEG_BLANK.
- Sub-module seg7_decode (combinational): 4-bit digit + blank flag + polarity -> 7-bit pattern.
- Double-dabble and refresh logic stay in the top.

Test Plan:
- Reset: hold rst=0 for 3 cycles with bin_valid=1 -> busy=0, bcd_valid=0, bcd_out=12'h000, dig_sel=001, seg_out=7'b0111111.
- Conversion: bin_in=8'd255, bin_valid 1 cycle -> busy high 9 cycles, bcd_valid single pulse at edge k+9, bcd_out=12'h255. Repeat for 0->12'h000 and 8'd9->12'h009.
- Blanking (REFRESH_DIV=4, BLANK_LZ=1):
  - bin_in=8'd7 -> hundreds and tens slots seg_out=0, ones=7'b0000111.
  - bin_in=8'd107 -> tens slot shows 7'b0111111, not blank.
- Busy lockout: bin_in=8'd200 accepted, then bin_in=8'd13 with bin_valid at cycles k+3 and k+9 -> bcd_out=12'h200, exactly one bcd_valid pulse, busy stays 0 afterwards.
- Reset mid-conversion: rst=0 at edge k+4 -> no bcd_valid, bcd_out=0, busy=0. The next request (bin_in=8'd42) yields 12'h042 with normal latency.
- Refresh rotation (REFRESH_DIV=4, SEG_ACTIVE_LOW=1):
  - dig_sel sequence 001,010,100,001 changing every 4 cycles.
  - seg_out is the inverted patterns for 12'h123: ones=~7'b1001111 (3), tens=~7'b1011011 (2), hundreds=~7'b0000110 (1).

Source files
------------

// File: rtl/cnt_disp_pkg.sv
// Shared types, widths and segment patterns for the counter BCD display.
package cnt_disp_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned BIN_W      = 8;
    localparam int unsigned BCD_W      = 12;
    localparam int unsigned WORK_W     = BIN_W + BCD_W;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned REF_W      = 16;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned SEG_W      = 7;

    // Common-cathode {g,f,e,d,c,b,a} patterns for digits 0-9.
    localparam logic [SEG_W-1:0] SEG_LUT [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] t;
        t = w;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        return {t[WORK_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment pattern with blanking and polarity.
module seg7_decode
    import cnt_disp_pkg::*;
(
    input  logic [3:0]       digit,
    input  logic             blank,
    input  logic             active_low,
    output logic [SEG_W-1:0] seg_c
);

    logic [SEG_W-1:0] pat;

    // Non-decimal nibbles fall through to blank.
    always_comb begin
        pat = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            pat = SEG_LUT[digit];
        end
        seg_c = pat ^ {SEG_W{active_low}};
    end

endmodule

// File: rtl/cnt_bcd_display.sv
// Binary-to-BCD double-dabble converter driving a multiplexed 3-digit 7-segment display.
module cnt_bcd_display
    import cnt_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          BLANK_LZ       = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             busy,
    output logic             bcd_valid,
    output logic [BCD_W-1:0] bcd_out,
    output logic [SEG_W-1:0] seg_out,
    output logic [2:0]       dig_sel
);

    state_e              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                bcd_valid_q, bcd_valid_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [REF_W-1:0]    ref_q, ref_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [2:0]          dig_sel_q, dig_sel_d;
    logic [SEG_W-1:0]    seg_q;
    logic [SEG_W-1:0]    seg_c;
    logic [3:0]          digit_c;
    logic                blank_c;

    // Conversion FSM; the bcd_valid cycle also refuses new requests.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bin_valid && !bcd_valid_q) begin
                    work_d  = WORK_W'(bin_in);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = dabble_step(work_q);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d       = work_q[WORK_W-1 -: BCD_W];
                bcd_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running refresh; digit select and segments both derive from the next-state index.
    always_comb begin
        ref_d = ref_q + REF_W'(1);
        idx_d = idx_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        dig_sel_d = 3'(3'b001 << idx_d);
        case (idx_d)
            2'd0: begin
                digit_c = bcd_d[3:0];
                blank_c = 1'b0;
            end
            2'd1: begin
                digit_c = bcd_d[7:4];
                blank_c = BLANK_LZ && (bcd_d[11:4] == 8'd0);
            end
            default: begin
                digit_c = bcd_d[11:8];
                blank_c = BLANK_LZ && (bcd_d[11:8] == 4'd0);
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .digit      (digit_c),
        .blank      (blank_c),
        .active_low (SEG_ACTIVE_LOW),
        .seg_c      (seg_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            bcd_valid_q <= 1'b0;
            bcd_q       <= '0;
            ref_q       <= '0;
            idx_q       <= '0;
            dig_sel_q   <= 3'b001;
            seg_q       <= SEG_LUT[0] ^ {SEG_W{SEG_ACTIVE_LOW}};
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            bcd_valid_q <= bcd_valid_d;
            bcd_q       <= bcd_d;
            ref_q       <= ref_d;
            idx_q       <= idx_d;
            dig_sel_q   <= dig_sel_d;
            seg_q       <= seg_c;
        end
    end

    assign busy      = busy_q;
    assign bcd_valid = bcd_valid_q;
    assign bcd_out   = bcd_q;
    assign seg_out   = seg_q;
    assign dig_sel   = dig_sel_q;

endmodule

// File: tb/tb_cnt_bcd_display.sv
// Directed self-checking bench for cnt_bcd_display (active-high/blanking and active-low/no-blank instances).
module tb_cnt_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  bin_in = 8'd0;
    logic        bin_valid = 1'b0;

    logic        busy_a, bcd_valid_a, busy_b, bcd_valid_b;
    logic [11:0] bcd_out_a, bcd_out_b;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  dig_a, dig_b;

    int n_chk  = 0;
    int n_pass = 0;
    int ncyc   = 0;

    always #5 clk = ~clk;

    // Edges since reset release: refresh slot = (ncyc/4)%3 for REFRESH_DIV=4.
    always @(posedge clk) begin
        if (!rst) ncyc <= 0;
        else      ncyc <= ncyc + 1;
    end

    cnt_bcd_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
        .busy(busy_a), .bcd_valid(bcd_valid_a), .bcd_out(bcd_out_a),
        .seg_out(seg_a), .dig_sel(dig_a)
    );

    cnt_bcd_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
        .busy(busy_b), .bcd_valid(bcd_valid_b), .bcd_out(bcd_out_b),
        .seg_out(seg_b), .dig_sel(dig_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] exp);
        int busy_cnt;
        int pulses;
        busy_cnt = 0;
        pulses   = 0;
        bin_in    = v;
        bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (busy_a) busy_cnt++;
            if (bcd_valid_a) pulses++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
        check({tag, "_early_valid"}, 32'(pulses), 32'd0);
        check({tag, "_valid"}, 32'(bcd_valid_a), 32'd1);
        check({tag, "_busy_drop"}, 32'(busy_a), 32'd0);
        check({tag, "_bcd"}, 32'(bcd_out_a), 32'(exp));
        check({tag, "_bcd_b"}, 32'(bcd_out_b), 32'(exp));
        tick();
        check({tag, "_valid_pulse"}, 32'(bcd_valid_a), 32'd0);
        check({tag, "_bcd_hold"}, 32'(bcd_out_a), 32'(exp));
    endtask

    // Expected patterns packed as {hundreds, tens, ones}, 7 bits each.
    task automatic show(input string tag, input logic [20:0] a_exp, input logic [20:0] b_exp);
        int slot;
        for (int i = 0; i < 12; i++) begin
            slot = (ncyc / 4) % 3;
            check({tag, "_dig_a"}, 32'(dig_a), 32'(3'(3'b001 << slot)));
            check({tag, "_dig_b"}, 32'(dig_b), 32'(3'(3'b001 << slot)));
            check({tag, "_seg_a"}, 32'(seg_a), 32'(a_exp[slot*7 +: 7]));
            check({tag, "_seg_b"}, 32'(seg_b), 32'(b_exp[slot*7 +: 7]));
            tick();
        end
    endtask

    initial begin
        int pulses;
        int busy_after;

        // Reset held with a pending request
        bin_in    = 8'd255;
        bin_valid = 1'b1;
        rst       = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_valid", 32'(bcd_valid_a), 32'd0);
        check("rst_bcd", 32'(bcd_out_a), 32'h000);
        check("rst_dig", 32'(dig_a), 32'b001);
        check("rst_seg_a", 32'(seg_a), 32'b0111111);
        check("rst_seg_b", 32'(seg_b), 32'b1000000);
        bin_valid = 1'b0;
        rst       = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy_a), 32'd0);

        convert("c255", 8'd255, 12'h255);
        convert("c0", 8'd0, 12'h000);
        convert("c9", 8'd9, 12'h009);

        // Busy lockout: requests during conversion and the bcd_valid cycle are dropped
        bin_in    = 8'd200;
        bin_valid = 1'b1;
        tick();
        pulses     = 0;
        busy_after = 0;
        for (int i = 1; i <= 20; i++) begin
            bin_in    = 8'd13;
            bin_valid = (i == 3 || i == 9 || i == 10);
            tick();
            if (bcd_valid_a) pulses++;
            if (i >= 9 && busy_a) busy_after++;
        end
        bin_valid = 1'b0;
        check("lock_pulses", 32'(pulses), 32'd1);
        check("lock_busy", 32'(busy_after), 32'd0);
        check("lock_bcd", 32'(bcd_out_a), 32'h200);

        // Reset mid-conversion
        bin_in    = 8'd99;
        bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_bcd", 32'(bcd_out_a), 32'h000);
        rst    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bcd_valid_a) pulses++;
        end
        check("abort_no_valid", 32'(pulses), 32'd0);
        check("abort_bcd_held", 32'(bcd_out_a), 32'h000);
        convert("c42", 8'd42, 12'h042);

        // Display rotation, blanking and polarity
        convert("c7", 8'd7, 12'h007);
        show("d7", {7'b0000000, 7'b0000000, 7'b0000111},
                   {7'b1000000, 7'b1000000, 7'b1111000});
        convert("c107", 8'd107, 12'h107);
        show("d107", {7'b0000110, 7'b0111111, 7'b0000111},
                     {7'b1111001, 7'b1000000, 7'b1111000});
        convert("c123", 8'd123, 12'h123);
        show("d123", {7'b0000110, 7'b1011011, 7'b1001111},
                     {7'b1111001, 7'b0100100, 7'b0110000});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
